// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz engine: controller states and
// the status codes reported with each result.
package collatz_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_STEP = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam logic [1:0] ST_OK  = 2'b00;  // sequence reached 1
   localparam logic [1:0] ST_OVF = 2'b01;  // next value would not fit in W bits
   localparam logic [1:0] ST_TMO = 2'b10;  // step limit reached
   localparam logic [1:0] ST_ERR = 2'b11;  // zero seed or aborted run

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: x/2 for even x, 3x+1 (or (3x+1)/2 in shortcut mode)
// for odd x. The odd branch is evaluated two bits wider than the datapath so
// that an out-of-range result is detected instead of silently truncated.
module collatz_step #(
   parameter int W        = 16,
   parameter bit SHORTCUT = 1'b0
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] next,
   output logic         ovf
);

   logic [W+1:0] x_ext_s;
   logic [W+1:0] t_s;
   logic [W+1:0] cand_s;

   // Compute the wide candidate value and flag any bits above the datapath.
   always_comb begin
      x_ext_s = {2'b00, x};
      t_s     = (x_ext_s << 1) + x_ext_s + {{(W+1){1'b0}}, 1'b1};
      if (x[0]) begin
         if (SHORTCUT) begin
            cand_s = t_s >> 1;
         end else begin
            cand_s = t_s;
         end
      end else begin
         cand_s = x_ext_s >> 1;
      end
      next = cand_s[W-1:0];
      ovf  = |cand_s[W+1:W];
   end

endmodule

// File: rtl/collatz_engine.sv
// Collatz-sequence engine: accepts a seed over a start/busy/done handshake,
// iterates one step per clock and reports step count, peak value and status.
module collatz_engine
   import collatz_pkg::*;
#(
   parameter int W         = 16,
   parameter int SW        = 10,
   parameter int MAX_STEPS = 1000,
   parameter bit SHORTCUT  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  seed,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] steps,
   output logic [W-1:0]  peak,
   output logic [1:0]    status
);

   // The step counter must be able to hold the limit without wrapping.
   if ((MAX_STEPS < 0) || (MAX_STEPS >= (2 ** SW))) begin : g_bad_max_steps
      $error("collatz_engine: MAX_STEPS must be in [0, 2**SW)");
   end

   localparam logic [SW-1:0] MAX_S  = SW'(MAX_STEPS);
   localparam logic [W-1:0]  X_ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] S_INC  = {{(SW-1){1'b0}}, 1'b1};

   state_e        state_q,  state_d;
   logic [W-1:0]  x_q,      x_d;
   logic [SW-1:0] steps_q,  steps_d;
   logic [W-1:0]  peak_q,   peak_d;
   logic [1:0]    status_q, status_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;

   logic [W-1:0]  next_s;
   logic          ovf_s;

   collatz_step #(
      .W        (W),
      .SHORTCUT (SHORTCUT)
   ) u_step (
      .x    (x_q),
      .next (next_s),
      .ovf  (ovf_s)
   );

   // Controller: next state, datapath updates and registered-output values.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      steps_d  = steps_q;
      peak_d   = peak_q;
      status_d = status_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (seed != {W{1'b0}}) begin
                  x_d      = seed;
                  peak_d   = seed;
                  steps_d  = {SW{1'b0}};
                  status_d = ST_OK;
                  state_d  = S_STEP;
               end else begin
                  peak_d   = {W{1'b0}};
                  steps_d  = {SW{1'b0}};
                  status_d = ST_ERR;
                  state_d  = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_STEP: begin
            if (abort) begin
               status_d = ST_ERR;
               state_d  = S_DONE;
            end else if (x_q == X_ONE) begin
               status_d = ST_OK;
               state_d  = S_DONE;
            end else if (steps_q == MAX_S) begin
               status_d = ST_TMO;
               state_d  = S_DONE;
            end else if (ovf_s) begin
               // Keep x, steps and peak at the last representable value.
               status_d = ST_OVF;
               state_d  = S_DONE;
            end else begin
               x_d     = next_s;
               steps_d = steps_q + S_INC;
               if (next_s > peak_q) begin
                  peak_d = next_s;
               end else begin
                  peak_d = peak_q;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_STEP);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset discards any run in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         x_q      <= {W{1'b0}};
         steps_q  <= {SW{1'b0}};
         peak_q   <= {W{1'b0}};
         status_q <= ST_OK;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         steps_q  <= steps_d;
         peak_q   <= peak_d;
         status_q <= status_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign steps  = steps_q;
   assign peak   = peak_q;
   assign status = status_q;

endmodule
